// File: rtl/wport_arbiter_if.sv
// Write-port bundle between requesters and the register-file arbiter.
interface wport_arbiter_if #(parameter int DW = 32);
  logic [3:0]    req;
  logic [4:0]    addr0, addr1, addr2, addr3;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          hold;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [4:0]    wa;
  logic [DW-1:0] wd;
  logic          we;
  logic [7:0]    wcnt;

  modport master (
    output req, addr0, addr1, addr2, addr3, data0, data1, data2, data3, hold,
    input  gnt, sel, wa, wd, we, wcnt
  );

  modport slave (
    input  req, addr0, addr1, addr2, addr3, data0, data1, data2, data3, hold,
    output gnt, sel, wa, wd, we, wcnt
  );
endinterface

// File: rtl/wport_arbiter.sv
// 4-way round-robin register-file write-port arbiter, 1-cycle registered grant.
module wport_arbiter #(
  parameter int DW = 32
) (
  input logic          clk,
  input logic          rstn,
  wport_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [1:0]    r_ptr;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic [4:0]    r_wa;
  logic [DW-1:0] r_wd;
  logic          r_we;
  logic [7:0]    r_wcnt;

  logic [4:0]    w_addr [4];
  logic [DW-1:0] w_data [4];
  logic [3:0]    w_req;
  logic [1:0]    w_idx  [4];
  logic [3:0]    w_hit;
  logic [1:0]    w_k;
  logic          w_go;
  logic          w_wen;

  assign w_addr[0] = bus.addr0;
  assign w_addr[1] = bus.addr1;
  assign w_addr[2] = bus.addr2;
  assign w_addr[3] = bus.addr3;
  assign w_data[0] = bus.data0;
  assign w_data[1] = bus.data1;
  assign w_data[2] = bus.data2;
  assign w_data[3] = bus.data3;

  // The requester being granted this cycle still has req high; mask it so
  // the same assertion is not granted again.
  assign w_req = bus.req & ~((r_state == GRANT) ? r_gnt : 4'b0000);

  // Search slot j looks at requester ptr+1+j; slot 3 wraps back to ptr itself.
  genvar j;
  generate
    for (j = 0; j < 4; j++) begin : g_slot
      assign w_idx[j] = r_ptr + 2'(j + 1);
      assign w_hit[j] = w_req[w_idx[j]];
    end
  endgenerate

  // Pick the first hit in search order (lowest slot wins).
  always_comb begin
    w_k = w_idx[3];
    for (int s = 3; s >= 0; s--)
      if (w_hit[s]) w_k = w_idx[s];
  end

  assign w_go  = (|w_req) & ~bus.hold;
  assign w_wen = (w_addr[w_k] != 5'd0);

  // FSM: GRANT whenever a grant is being registered, IDLE otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_go ? GRANT : IDLE;
  end

  // Grant / write-port registers; sel, wa, wd, ptr hold when nothing is granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= 2'd3;
      r_gnt <= '0;
      r_sel <= '0;
      r_wa  <= '0;
      r_wd  <= '0;
      r_we  <= 1'b0;
    end else if (w_go) begin
      r_ptr <= w_k;
      r_gnt <= 4'b0001 << w_k;
      r_sel <= w_k;
      r_wa  <= w_addr[w_k];
      r_wd  <= w_data[w_k];
      r_we  <= w_wen;
    end else begin
      r_gnt <= '0;
      r_we  <= 1'b0;
    end
  end

  // Committed-write counter, updated alongside we so it already reflects the
  // write in the cycle we is high; r0 writes are not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              r_wcnt <= '0;
    else if (w_go && w_wen) r_wcnt <= r_wcnt + 8'd1;
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.wa   = r_wa;
  assign bus.wd   = r_wd;
  assign bus.we   = r_we;
  assign bus.wcnt = r_wcnt;
endmodule

// File: tb/tb_wport_arbiter.sv
// Scoreboard bench for wport_arbiter: stimulus pushes model predictions,
// a monitor pops and compares after each rising edge.
module tb_wport_arbiter;
  logic clk = 1'b0;
  logic rstn;

  wport_arbiter_if #(.DW(32)) bus ();

  wport_arbiter #(.DW(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [7:0]  wcnt;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  // reference model state: what the DUT should present after the next edge
  int          m_ptr;
  logic [3:0]  m_gnt;
  logic [1:0]  m_sel;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_we;
  logic [7:0]  m_wcnt;

  logic [4:0]  ta [4];
  logic [31:0] td [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 3; m_gnt = '0; m_sel = '0; m_wa = '0; m_wd = '0; m_we = 1'b0; m_wcnt = '0;
  endtask

  // Drive one cycle of inputs at the falling edge and predict the next edge.
  task automatic step(input logic [3:0] r, input logic h);
    logic [3:0] cand;
    int k;
    exp_t e;
    @(negedge clk);
    bus.req = r; bus.hold = h;
    bus.addr0 = ta[0]; bus.addr1 = ta[1]; bus.addr2 = ta[2]; bus.addr3 = ta[3];
    bus.data0 = td[0]; bus.data1 = td[1]; bus.data2 = td[2]; bus.data3 = td[3];
    if (!rstn) model_reset();
    else begin
      cand = r & ~m_gnt;
      k = -1;
      if (!h)
        for (int o = 1; o <= 4; o++)
          if (k < 0 && cand[(m_ptr + o) % 4]) k = (m_ptr + o) % 4;
      if (k >= 0) begin
        m_gnt = 4'(1 << k);
        m_sel = 2'(k);
        m_wa  = ta[k];
        m_wd  = td[k];
        m_we  = (ta[k] != 5'd0);
        if (m_we) m_wcnt = m_wcnt + 8'd1;
        m_ptr = k;
      end else begin
        m_gnt = '0;
        m_we  = 1'b0;
      end
    end
    e.gnt = m_gnt; e.sel = m_sel; e.wa = m_wa; e.wd = m_wd; e.we = m_we; e.wcnt = m_wcnt;
    sbq.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt),  32'd0);
    chk({tag, "_sel"},  32'(bus.sel),  32'd0);
    chk({tag, "_we"},   32'(bus.we),   32'd0);
    chk({tag, "_wcnt"}, 32'(bus.wcnt), 32'd0);
    chk({tag, "_wa"},   32'(bus.wa),   32'd0);
    chk({tag, "_wd"},   bus.wd,        32'd0);
  endtask

  // Asynchronous reset pulse dropped between edges, checked before the next edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk_reset_outputs(tag);
    model_reset();
    step(4'b0000, 1'b0);
    @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("gnt",  32'(bus.gnt),  32'(e.gnt));
        chk("sel",  32'(bus.sel),  32'(e.sel));
        chk("wa",   32'(bus.wa),   32'(e.wa));
        chk("wd",   bus.wd,        e.wd);
        chk("we",   32'(bus.we),   32'(e.we));
        chk("wcnt", 32'(bus.wcnt), 32'(e.wcnt));
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] rq;
    logic       h;
    rstn = 1'b0;
    bus.req = '0; bus.hold = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0; bus.addr3 = '0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0; bus.data3 = '0;
    for (int i = 0; i < 4; i++) begin ta[i] = '0; td[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("por");
    #2 rstn = 1'b1;

    // full contention, nonzero addresses: rotation 0,1,2,3,0,...
    for (int i = 0; i < 4; i++) begin ta[i] = 5'(i + 1); td[i] = $urandom; end
    repeat (8) step(4'b1111, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // stall, then release
    repeat (3) step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);

    // single request
    ta[1] = 5'd5; td[1] = 32'hDEADBEEF;
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);

    // r0 write suppressed, gnt still pulses
    ta[2] = 5'd0;
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);

    // reset while gnt=1000, then req=1010 must go to requester 1 first
    ta[3] = 5'd9; td[3] = $urandom;
    step(4'b1000, 1'b0);
    mid_reset("midrst");
    step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);

    // 256 counted writes wrap wcnt back to 0
    mid_reset("prewrap");
    for (int i = 0; i < 4; i++) begin ta[i] = 5'(i + 20); td[i] = $urandom; end
    repeat (256) step(4'b1111, 1'b0);
    @(posedge clk);
    #2 chk("wrap_wcnt", 32'(bus.wcnt), 32'd0);
    step(4'b0000, 1'b0);

    // random traffic; a requester keeps req until it sees its grant
    rq = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && m_gnt[i]) rq[i] = 1'($urandom_range(0, 1));
        else if (!rq[i])       rq[i] = ($urandom_range(0, 2) == 0);
        ta[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        td[i] = $urandom;
      end
      h = ($urandom_range(0, 4) == 0);
      step(rq, h);
    end

    repeat (2) step(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #2 chk("drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wport_arbiter.md
WPORT_ARBITER -- requirements
Module: wport_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, setting the write-data width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits, one write request per requester 0..3.
REQ-005 The block SHALL have ports addr0..addr3, input, 5 bits each, destination register address per requester.
REQ-006 The block SHALL have ports data0..data3, input, DW bits each, write data per requester.
REQ-007 The block SHALL have port hold, input, 1 bit, pipeline stall; blocks new grants.
REQ-008 The block SHALL have port gnt, output, 4 bits, one-hot grant pulse.
REQ-009 The block SHALL have port sel, output, 2 bits, select code for the 5-bit 4:1 address mux: 0..3 map to requester 0..3.
REQ-010 The block SHALL have port wa, output, 5 bits, register-file write address.
REQ-011 The block SHALL have port wd, output, DW bits, register-file write data.
REQ-012 The block SHALL have port we, output, 1 bit, register-file write enable.
REQ-013 The block SHALL have port wcnt, output, 8 bits, count of committed writes.

Function
REQ-014 Arbitration SHALL be round-robin over a 2-bit pointer ptr holding the index last granted; search order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-015 A request sampled at edge N SHALL produce gnt, sel, wa, wd and we, all registered, valid in cycle N+1 (1-cycle latency).
REQ-016 At most one gnt bit SHALL be high per cycle; each gnt is a single-cycle pulse.
REQ-017 A requester SHALL keep req high until it sees its gnt bit; it may drop or re-raise req in the cycle gnt is high.
REQ-018 During arbitration, the requester whose gnt bit is currently high SHALL be masked, so one req assertion is never granted twice.
REQ-019 The block SHALL have two states: IDLE (no grant in flight) and GRANT (gnt/we registered this cycle).
REQ-020 IDLE->GRANT SHALL occur when any unmasked req is high and hold=0; GRANT->GRANT occurs under the same condition, otherwise GRANT->IDLE.
REQ-021 On grant to index k: sel=k, wa=addr_k, wd=data_k, gnt=1<<k, ptr<=k.
REQ-022 we SHALL be 1 with the grant unless addr_k=0, in which case we=0 (r0 is never written) but gnt still pulses.
REQ-023 When hold=1, no grant SHALL issue; gnt=0 and we=0 next cycle; ptr, sel, wa and wd hold their values; pending reqs wait.
REQ-024 In cycles with no grant, gnt=0 and we=0; sel, wa and wd SHALL retain their last values.
REQ-025 wcnt SHALL increment by 1 on every cycle with we=1, wrapping 255->0; suppressed r0 writes do not count.
REQ-026 With all four req high continuously, grants SHALL rotate 0,1,2,3,0,... with no requester starved for more than 3 grants.

Reset
REQ-027 rstn=0 SHALL immediately, without waiting for clk, force state=IDLE, ptr=3, gnt=0, sel=0, wa=0, wd=0, we=0 and wcnt=0.
REQ-028 Reset asserted mid-grant SHALL drop gnt and we at once; the interrupted write is not retried and is not counted.
REQ-029 The first grant after reset deassertion SHALL go to the lowest-indexed active requester (ptr=3 gives order 0,1,2,3).

Verification
REQ-030 Single request: req=0010, addr1=5, data1=0xDEADBEEF -> next cycle gnt=0010, sel=1, wa=5, wd=0xDEADBEEF, we=1, wcnt=1.
REQ-031 Full contention: req=1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; wcnt=8 if all addresses are nonzero.
REQ-032 r0 suppression: req=0100, addr2=0 -> gnt=0100, sel=2, we=0, wcnt unchanged.
REQ-033 Stall: req=1001 with hold=1 for 3 cycles -> gnt=0, we=0 throughout; the cycle after hold falls, gnt=0001.
REQ-034 Reset mid-operation: rstn pulled low between edges while gnt=1000 -> gnt, we, wcnt and sel read 0 before the next edge; after release, req=1010 is granted 0010 first.
REQ-035 Wrap: 256 unsuppressed writes -> wcnt returns to 0.
